// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the data memory responder and its lane formatter.
package data_mem_pkg;

  typedef enum logic [2:0] {
    FMT_B  = 3'b000,
    FMT_H  = 3'b001,
    FMT_W  = 3'b010,
    FMT_BU = 3'b100,
    FMT_HU = 3'b101
  } mem_format_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESPOND
  } responder_state_t;

  localparam int BYTE_MASK_WIDTH = 4;

  // Undefined funct3 codes behave as word accesses, so they share the word alignment rule.
  function automatic logic is_misaligned(input logic [2:0] format, input logic [1:0] offset);
    case (format)
      FMT_B, FMT_BU: is_misaligned = 1'b0;
      FMT_H, FMT_HU: is_misaligned = offset[0];
      default:       is_misaligned = (offset != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/data_mem_formatter.sv
// Combinational lane logic: extracts/extends load values and merges store data into a word.
module data_mem_formatter
  import data_mem_pkg::*;
(
  input  logic [2:0]                 format,
  input  logic [1:0]                 byte_offset,
  input  logic [31:0]                raw_word,
  input  logic [31:0]                store_data,
  output logic [31:0]                load_value,
  output logic [31:0]                store_word,
  output logic [BYTE_MASK_WIDTH-1:0] byte_mask
);

  logic [1:0]  lane;
  logic [31:0] shifted_word;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] lane_data;

  always_comb begin
    lane         = 2'b00;
    load_value   = raw_word;
    byte_mask    = 4'b1111;
    lane_data    = store_data;
    store_word   = raw_word;

    // Halfwords snap to their halfword, words to lane 0; misalignment is handled upstream.
    case (format)
      FMT_B, FMT_BU: lane = byte_offset;
      FMT_H, FMT_HU: lane = {byte_offset[1], 1'b0};
      default:       lane = 2'b00;
    endcase

    shifted_word = raw_word >> {lane, 3'b000};
    sel_byte     = shifted_word[7:0];
    sel_half     = shifted_word[15:0];

    case (format)
      FMT_B: begin
        load_value = {{24{sel_byte[7]}}, sel_byte};
        byte_mask  = 4'b0001 << lane;
        lane_data  = {4{store_data[7:0]}};
      end
      FMT_BU: begin
        load_value = {24'h0, sel_byte};
        byte_mask  = 4'b0001 << lane;
        lane_data  = {4{store_data[7:0]}};
      end
      FMT_H: begin
        load_value = {{16{sel_half[15]}}, sel_half};
        byte_mask  = 4'b0011 << lane;
        lane_data  = {2{store_data[15:0]}};
      end
      FMT_HU: begin
        load_value = {16'h0, sel_half};
        byte_mask  = 4'b0011 << lane;
        lane_data  = {2{store_data[15:0]}};
      end
      default: begin
        load_value = raw_word;
        byte_mask  = 4'b1111;
        lane_data  = store_data;
      end
    endcase

    for (int i = 0; i < BYTE_MASK_WIDTH; i++) begin
      store_word[8*i +: 8] = byte_mask[i] ? lane_data[8*i +: 8] : raw_word[8*i +: 8];
    end
  end

endmodule

// File: rtl/data_memory_responder.sv
// Data memory responder: sized loads/stores over a word RAM with a fixed response latency.
// Define DATA_MEM_MISALIGNED_ERROR_EN to flag and suppress misaligned accesses instead of aligning them.
module data_memory_responder
  import data_mem_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 12,
  parameter int LATENCY       = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        read_enable,
  input  logic        write_enable,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic [2:0]  format,
  output logic [31:0] read_data,
  output logic        data_available,
`ifdef DATA_MEM_MISALIGNED_ERROR_EN
  output logic        request_successful,
  output logic        misaligned_error
`else
  output logic        request_successful
`endif
);

  localparam int         WORDS      = 2 ** ADDRESS_WIDTH;
  localparam logic [3:0] COUNT_INIT = 4'(LATENCY - 1);

  responder_state_t         state_q, state_d;
  logic [3:0]               count_q, count_d;
  logic [ADDRESS_WIDTH+1:0] address_q, address_d;
  logic [2:0]               format_q, format_d;
  logic [31:0]              write_data_q, write_data_d;
  logic                     is_write_q, is_write_d;
  logic [31:0]              read_data_q, read_data_d;
  logic                     data_available_q, data_available_d;
  logic                     request_successful_q, request_successful_d;
`ifdef DATA_MEM_MISALIGNED_ERROR_EN
  logic                     misaligned_error_q, misaligned_error_d;
`endif

  logic [31:0]                mem [WORDS];
  logic                       request;
  logic [ADDRESS_WIDTH+1:0]   access_address;
  logic [ADDRESS_WIDTH-1:0]   word_index;
  logic [2:0]                 access_format;
  logic                       access_is_write;
  logic [31:0]                raw_word;
  logic [31:0]                load_value;
  logic [31:0]                store_word;
  logic [BYTE_MASK_WIDTH-1:0] byte_mask;
  logic                       enter_respond;
  logic                       suppress;
  logic                       commit;
  logic                       unused_address_bits;

  assign unused_address_bits = ^address[31:ADDRESS_WIDTH+2];
  assign request             = read_enable | write_enable;

  // With LATENCY=1 the RAM is read straight from IDLE, before the request has been latched.
  assign access_address  = (state_q == IDLE) ? address[ADDRESS_WIDTH+1:0] : address_q;
  assign access_format   = (state_q == IDLE) ? format : format_q;
  assign access_is_write = (state_q == IDLE) ? ~read_enable : is_write_q;
  assign word_index      = access_address[ADDRESS_WIDTH+1:2];
  assign raw_word        = mem[word_index];

`ifdef DATA_MEM_MISALIGNED_ERROR_EN
  assign suppress = is_misaligned(access_format, access_address[1:0]);
`else
  assign suppress = 1'b0;
`endif

  assign commit = (state_q == RESPOND) && is_write_q && !suppress;

  data_mem_formatter u_formatter (
    .format      (access_format),
    .byte_offset (access_address[1:0]),
    .raw_word    (raw_word),
    .store_data  (write_data_q),
    .load_value  (load_value),
    .store_word  (store_word),
    .byte_mask   (byte_mask)
  );

  always_comb begin
    state_d              = state_q;
    count_d              = count_q;
    address_d            = address_q;
    format_d             = format_q;
    write_data_d         = write_data_q;
    is_write_d           = is_write_q;
    read_data_d          = read_data_q;
    data_available_d     = 1'b0;
    request_successful_d = 1'b0;
    enter_respond        = 1'b0;
`ifdef DATA_MEM_MISALIGNED_ERROR_EN
    misaligned_error_d   = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (request) begin
          address_d    = address[ADDRESS_WIDTH+1:0];
          format_d     = format;
          write_data_d = write_data;
          is_write_d   = ~read_enable;
          count_d      = COUNT_INIT;
          if (LATENCY == 1) enter_respond = 1'b1;
          else              state_d       = WAIT;
        end
      end
      WAIT: begin
        // The requester must hold an enable through WAIT; dropping both abandons the access.
        if (!request) begin
          state_d = IDLE;
        end else begin
          count_d = count_q - 4'd1;
          if (count_q == 4'd1) enter_respond = 1'b1;
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (enter_respond) begin
      state_d              = RESPOND;
      data_available_d     = ~access_is_write;
      request_successful_d = access_is_write;
      if (!access_is_write) read_data_d = suppress ? 32'h0 : load_value;
`ifdef DATA_MEM_MISALIGNED_ERROR_EN
      misaligned_error_d   = suppress;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q              <= IDLE;
      count_q              <= 4'd0;
      address_q            <= '0;
      format_q             <= 3'b000;
      write_data_q         <= 32'h0;
      is_write_q           <= 1'b0;
      read_data_q          <= 32'h0;
      data_available_q     <= 1'b0;
      request_successful_q <= 1'b0;
`ifdef DATA_MEM_MISALIGNED_ERROR_EN
      misaligned_error_q   <= 1'b0;
`endif
    end else begin
      state_q              <= state_d;
      count_q              <= count_d;
      address_q            <= address_d;
      format_q             <= format_d;
      write_data_q         <= write_data_d;
      is_write_q           <= is_write_d;
      read_data_q          <= read_data_d;
      data_available_q     <= data_available_d;
      request_successful_q <= request_successful_d;
`ifdef DATA_MEM_MISALIGNED_ERROR_EN
      misaligned_error_q   <= misaligned_error_d;
`endif
    end
  end

  // Stores commit on the edge leaving RESPOND; a reset on that edge drops them.
  always_ff @(posedge clock) begin
    if (!reset && commit) begin
      for (int i = 0; i < BYTE_MASK_WIDTH; i++) begin
        if (byte_mask[i]) mem[word_index][8*i +: 8] <= store_word[8*i +: 8];
      end
    end
  end

  assign read_data          = read_data_q;
  assign data_available     = data_available_q;
  assign request_successful = request_successful_q;
`ifdef DATA_MEM_MISALIGNED_ERROR_EN
  assign misaligned_error   = misaligned_error_q;
`endif

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed self-checking bench for data_memory_responder (LATENCY=2, ADDRESS_WIDTH=12).
module tb_data_memory_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic        read_enable;
  logic        write_enable;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [2:0]  format;
  logic [31:0] read_data;
  logic        data_available;
  logic        request_successful;
`ifdef DATA_MEM_MISALIGNED_ERROR_EN
  logic        misaligned_error;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [31:0] obs_read_data;
  int          obs_latency;
  logic        obs_available;
  logic        obs_successful;
  logic        obs_misaligned;
  int          strobes;

  localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;

  always #5 clock = ~clock;

  data_memory_responder #(.ADDRESS_WIDTH(12), .LATENCY(2)) dut (
    .clock              (clock),
    .reset              (reset),
    .read_enable        (read_enable),
    .write_enable       (write_enable),
    .address            (address),
    .write_data         (write_data),
    .format             (format),
    .read_data          (read_data),
    .data_available     (data_available),
`ifdef DATA_MEM_MISALIGNED_ERROR_EN
    .request_successful (request_successful),
    .misaligned_error   (misaligned_error)
`else
    .request_successful (request_successful)
`endif
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  // Holds the request until a strobe appears (bounded), then returns in the following IDLE cycle.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [2:0] fmt);
    read_enable    = rd;
    write_enable   = wr;
    address        = addr;
    write_data     = wdata;
    format         = fmt;
    obs_latency    = -1;
    obs_available  = 1'b0;
    obs_successful = 1'b0;
    obs_misaligned = 1'b0;
    obs_read_data  = 32'h0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (data_available || request_successful) begin
        obs_latency    = n;
        obs_available  = data_available;
        obs_successful = request_successful;
        obs_read_data  = read_data;
`ifdef DATA_MEM_MISALIGNED_ERROR_EN
        obs_misaligned = misaligned_error;
`endif
        break;
      end
    end
    read_enable  = 1'b0;
    write_enable = 1'b0;
    tick();
  endtask

  task automatic doStore(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] fmt);
    applyStimulus(1'b0, 1'b1, addr, wdata, fmt);
    checkOutput({tag, "_latency"}, 32'(obs_latency), 32'd2);
    checkOutput({tag, "_success"}, 32'(obs_successful), 32'd1);
    checkOutput({tag, "_no_avail"}, 32'(obs_available), 32'd0);
  endtask

  task automatic doLoad(input string tag, input logic [31:0] addr, input logic [2:0] fmt,
                        input logic [31:0] expected);
    applyStimulus(1'b1, 1'b0, addr, 32'h0, fmt);
    checkOutput({tag, "_latency"}, 32'(obs_latency), 32'd2);
    checkOutput({tag, "_avail"}, 32'(obs_available), 32'd1);
    checkOutput({tag, "_data"}, obs_read_data, expected);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] simulation timed out");
  end

  initial begin
    reset        = 1'b1;
    read_enable  = 1'b0;
    write_enable = 1'b0;
    address      = 32'h0;
    write_data   = 32'h0;
    format       = F_W;
    tick();
    tick();
    checkOutput("reset_read_data", read_data, 32'h0);
    checkOutput("reset_avail", 32'(data_available), 32'd0);
    checkOutput("reset_success", 32'(request_successful), 32'd0);
    reset = 1'b0;

    $display("[TB] store/load round trip");
    doStore("sw_100", 32'h100, 32'hDEADBEEF, F_W);
    doLoad("lw_100", 32'h100, F_W, 32'hDEADBEEF);
    checkOutput("hold_read_data", read_data, 32'hDEADBEEF);
    checkOutput("hold_no_avail", 32'(data_available), 32'd0);

    $display("[TB] load formatting");
    doStore("sw_40", 32'h40, 32'h80817F01, F_W);
    doLoad("lb_43", 32'h43, F_B, 32'hFFFFFF80);
    doLoad("lbu_43", 32'h43, F_BU, 32'h00000080);
    doLoad("lh_42", 32'h42, F_H, 32'hFFFF8081);
    doLoad("lhu_40", 32'h40, F_HU, 32'h00007F01);
    doLoad("lb_41", 32'h41, F_B, 32'h0000007F);
    doLoad("fmt011_as_w", 32'h40, 3'b011, 32'h80817F01);
    doLoad("alias_lw", 32'h0000_4040, F_W, 32'h80817F01);

    $display("[TB] partial stores");
    doStore("sw_60", 32'h60, 32'h11223344, F_W);
    doStore("sb_61", 32'h61, 32'h123456AA, F_B);
    doLoad("lw_60_after_sb", 32'h60, F_W, 32'h1122AA44);
    doStore("sh_62", 32'h62, 32'h9999CAFE, F_H);
    doLoad("lw_60_after_sh", 32'h60, F_W, 32'hCAFEAA44);

    $display("[TB] aborted store");
    doStore("sw_20", 32'h20, 32'h11111111, F_W);
    read_enable  = 1'b0;
    write_enable = 1'b1;
    address      = 32'h20;
    write_data   = 32'h12345678;
    format       = F_W;
    tick();
    write_enable = 1'b0;
    strobes = 0;
    for (int n = 0; n < 4; n++) begin
      tick();
      if (data_available || request_successful) strobes++;
    end
    checkOutput("abort_no_strobe", 32'(strobes), 32'd0);
    doLoad("lw_20_after_abort", 32'h20, F_W, 32'h11111111);

    $display("[TB] reset during wait");
    read_enable = 1'b1;
    address     = 32'h100;
    format      = F_W;
    tick();
    reset       = 1'b1;
    read_enable = 1'b0;
    tick();
    checkOutput("midreset_read_data", read_data, 32'h0);
    checkOutput("midreset_avail", 32'(data_available), 32'd0);
    checkOutput("midreset_success", 32'(request_successful), 32'd0);
    reset = 1'b0;
    doLoad("lw_after_reset", 32'h100, F_W, 32'hDEADBEEF);

    $display("[TB] misaligned accesses");
    doStore("sw_200", 32'h200, 32'h00000000, F_W);
    applyStimulus(1'b0, 1'b1, 32'h203, 32'h0000BEEF, F_H);
    checkOutput("sh_203_latency", 32'(obs_latency), 32'd2);
    checkOutput("sh_203_success", 32'(obs_successful), 32'd1);
`ifdef DATA_MEM_MISALIGNED_ERROR_EN
    checkOutput("sh_203_flag", 32'(obs_misaligned), 32'd1);
    doLoad("lw_200_unchanged", 32'h200, F_W, 32'h00000000);
    checkOutput("aligned_no_flag", 32'(obs_misaligned), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h41, 32'h0, F_W);
    checkOutput("lw_41_flag", 32'(obs_misaligned), 32'd1);
    checkOutput("lw_41_data", obs_read_data, 32'h0);
`else
    checkOutput("sh_203_no_flag", 32'(obs_misaligned), 32'd0);
    doLoad("lw_200_aligned", 32'h200, F_W, 32'hBEEF0000);
    doLoad("lw_41_aligned", 32'h41, F_W, 32'h80817F01);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_memory_responder.md
# data_memory_responder

Memory-side responder for the core's data memory port: serves the load/store requests the pipelined datapath issues from its MEM stage. Sized-access formatting (byte/half/word, signed/unsigned) over a word-organised RAM. Completion is signalled with `data_available` for reads and `request_successful` for writes after a configurable latency. It sits between the core's data memory port and the on-chip data RAM, and stands in for slower memories in simulation.

## Interface
- `ADDRESS_WIDTH`, 12: word-address bits; the RAM holds 2^ADDRESS_WIDTH 32-bit words.
- `LATENCY`, 2: cycles from request acceptance to response; legal range 1..15.

- `clock`  in  1: sole clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `read_enable`  in  1: load request.
- `write_enable`  in  1: store request.
- `address`  in  32: byte address.
- `write_data`  in  32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `format`  in  3: RISC-V funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `read_data`  out  32: formatted load result, valid only while `data_available`=1.
- `data_available`  out  1: one-cycle load completion.
- `request_successful`  out  1: one-cycle store completion.

## Operation
- Reset: state IDLE; `read_data`=0, `data_available`=0, `request_successful`=0. The RAM contents are not cleared.
- FSM states: IDLE, WAIT, RESPOND.
- IDLE:
  - If `read_enable` or `write_enable`, latch address, format, write_data and the request kind.
  - Load the counter with LATENCY-1.
  - Go to RESPOND if LATENCY=1, else to WAIT.
  - If both enables are high, the request is a read and the write is ignored.
- WAIT:
  - Decrement the counter; go to RESPOND when it reaches 0.
  - If both enables are low in any WAIT cycle, abort to IDLE: no RAM write, no response.
- On the edge entering RESPOND:
  - For a read, the RAM word is read and formatted into `read_data`.
  - A write is not committed on this edge.
- RESPOND, one cycle:
  - Asserts `data_available` for a read, `request_successful` for a write.
  - The write commits on the edge leaving RESPOND, using a byte mask from format and address[1:0].
  - Always returns to IDLE.
- Each IDLE cycle with an enable high is a new request, even if identical to the previous one. A repeated store is idempotent.
- Load formatting, little-endian:
  - B/H: selected lane, sign-extended.
  - BU/HU: selected lane, zero-extended.
  - W: whole word.
  - Formats 011/110/111 are treated as W.
- Word index is address[ADDRESS_WIDTH+1:2]; higher address bits are ignored (aliasing).
- Misaligned access means H/HU with address[0]=1, or W with address[1:0]≠0. Its handling is set by the macro in Configuration.

## Timing
- Request first seen in cycle t → response in cycle t+LATENCY.
- Sustained throughput is one access per LATENCY+1 cycles: one IDLE cycle follows every RESPOND.
- `read_data` is registered; it holds its value after RESPOND but is meaningful only while `data_available`=1.
- Store then load to the same word: the load starts in the IDLE cycle after the store's RESPOND and returns the new data.
- Reset in any state returns to IDLE on that edge; a pending write is dropped.

## Configuration
- `DATA_MEM_MISALIGNED_ERROR_EN` defined:
  - Adds output `misaligned_error` (1 bit, reset 0), pulsed in RESPOND together with the normal completion strobe.
  - A misaligned store does not write.
  - A misaligned load returns 0.
- Macro undefined:
  - No extra port.
  - Offending low address bits are forced to zero: H aligns to the halfword, W to the word.
  - The access proceeds normally.

## Structure
- Shared package `data_mem_pkg`:
  - `mem_format_t` enum for the funct3 codes above.
  - `responder_state_t` enum (IDLE, WAIT, RESPOND).
  - Byte-mask width constant.
- One sub-module, `data_mem_formatter`:
  - Combinational.
  - Inputs: format, address[1:0], raw word, store data.
  - Outputs: formatted load value, merged store word, byte mask.
- RAM is an inferred array inside the top module.

## Test plan
- LATENCY=2: SW 0xDEADBEEF to 0x100 at cycle 0, then LW 0x100 → `request_successful` at cycle 2, `data_available` at cycle 5 with `read_data`=0xDEADBEEF.
- After word 0x8081_7F01 is stored at 0x40:
  - LB 0x43 → 0xFFFFFF80.
  - LBU 0x43 → 0x00000080.
  - LH 0x42 → 0xFFFF8081.
  - LHU 0x40 → 0x00007F01.
- SB 0xAA to 0x41 over word 0x11223344, then LW → 0x1122AA44; the other lanes are unchanged.
- SW 0x12345678 to 0x20, then drop `write_enable` in a WAIT cycle → no strobe; a later LW 0x20 returns the prior contents.
- `reset` pulsed in WAIT during a read → outputs 0 on the next cycle; a new request is accepted immediately after.
- SH 0xBEEF to 0x203 over word 0:
  - With the macro: `misaligned_error`=1, memory unchanged.
  - Without it: LW 0x200 → 0xBEEF0000.
